kamacore_mem_arbiter: RTL

//  Shares the single-port kamacore_memory between the instruction-fetch stage (IF) and the

---
 rtl/kamacore_mem_arbiter_if.sv | 49 ++++
 rtl/kamacore_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/kamacore_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// kamacore_mem_arbiter_if
// Purpose : Request/response handshake bundle between the two memory clients
//           (instruction fetch "IF" and load/store "LS") and the memory arbiter.
// Signals :
//   if_req_valid/ready/addr   fetch read request
//   if_flush                  branch redirect, kills an in-flight fetch
//   if_rsp_valid/ready/data   fetch response (instruction word)
//   ls_req_valid/ready/we/addr/wdata   load/store request
//   ls_rsp_valid/ready/data   load response
// Modports:
//   master  the CPU side (drives requests, consumes responses)
//   slave   the arbiter side
// ----------------------------------------------------------------------------
interface kamacore_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  if_flush;
    logic                  if_rsp_valid;
    logic                  if_rsp_ready;
    logic [DATA_WIDTH-1:0] if_rsp_data;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic                  ls_req_we;
    logic [ADDR_WIDTH-1:0] ls_req_addr;
    logic [DATA_WIDTH-1:0] ls_req_wdata;
    logic                  ls_rsp_valid;
    logic                  ls_rsp_ready;
    logic [DATA_WIDTH-1:0] ls_rsp_data;

    modport master (
        output if_req_valid, if_req_addr, if_flush, if_rsp_ready,
        output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_rsp_ready,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data
    );

    modport slave (
        input  if_req_valid, if_req_addr, if_flush, if_rsp_ready,
        input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_rsp_ready,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data
    );
endinterface

// File: rtl/kamacore_mem_arbiter.sv
// ----------------------------------------------------------------------------
// kamacore_mem_arbiter
// Purpose : Shares one single-port kamacore_memory between instruction fetch
//           (IF) and the load/store unit (LS). One access at a time is run
//           through an IDLE -> ACCESS -> (RESP) -> IDLE sequence; read data is
//           returned on a valid/ready handshake. A branch redirect (if_flush)
//           discards an in-flight fetch.
// Ports   :
//   clk        core clock, all state on posedge
//   rst        synchronous active-high reset
//   bus        kamacore_mem_arbiter_if.slave (IF/LS request and response)
//   mem_we_o   write enable to kamacore_memory.we
//   mem_a_o    word address to kamacore_memory.a
//   mem_di_o   write data to kamacore_memory.di
//   mem_spo_i  combinational read data of mem_a_o
//   busy_o     arbiter is not idle
// Config  :
//   KAMACORE_ARB_ROUND_ROBIN_EN  undefined: LS has fixed priority over IF.
//                                defined: on contention the requester that did
//                                not win last time is granted.
// ----------------------------------------------------------------------------
module kamacore_mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    kamacore_mem_arbiter_if.slave bus,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [DATA_WIDTH-1:0] mem_di_o,
    input  logic [DATA_WIDTH-1:0] mem_spo_i,
    output logic                  busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    logic [1:0]            state_q,     state_d;
    logic                  owner_q,     owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  we_q,        we_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0] ifRspData_q, ifRspData_d;
    logic [DATA_WIDTH-1:0] lsRspData_q, lsRspData_d;

    logic ifCand;
    logic lsCand;
    logic grantIf;
    logic grantLs;

`ifdef KAMACORE_ARB_ROUND_ROBIN_EN
    logic lastGrant_q;
`endif

    // Arbitration. A flush in IDLE removes IF from contention for that cycle.
    // Grants are only ever issued from IDLE, so they double as req_ready.
    always_comb begin
        ifCand = bus.if_req_valid & ~bus.if_flush;
        lsCand = bus.ls_req_valid;
`ifdef KAMACORE_ARB_ROUND_ROBIN_EN
        if (ifCand && lsCand) begin
            grantLs = (lastGrant_q == OWNER_IF);
        end else begin
            grantLs = lsCand;
        end
`else
        grantLs = lsCand;
`endif
        grantIf = ifCand & ~grantLs;
        if (state_q != S_IDLE) begin
            grantLs = 1'b0;
            grantIf = 1'b0;
        end
    end

`ifdef KAMACORE_ARB_ROUND_ROBIN_EN
    // Remembers the last winner so contention alternates between clients.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= OWNER_IF;
        end else if (grantLs) begin
            lastGrant_q <= OWNER_LS;
        end else if (grantIf) begin
            lastGrant_q <= OWNER_IF;
        end
    end
`endif

    // Next-state logic. The latched address/data registers double as the
    // memory port drivers, so they naturally hold their value outside ACCESS.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        ifRspData_d = ifRspData_q;
        lsRspData_d = lsRspData_q;

        case (state_q)
            S_IDLE: begin
                if (grantLs) begin
                    owner_d = OWNER_LS;
                    addr_d  = bus.ls_req_addr;
                    we_d    = bus.ls_req_we;
                    wdata_d = bus.ls_req_wdata;
                    state_d = S_ACCESS;
                end else if (grantIf) begin
                    owner_d = OWNER_IF;
                    addr_d  = bus.if_req_addr;
                    we_d    = 1'b0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else if (owner_q == OWNER_IF && bus.if_flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (owner_q == OWNER_IF) begin
                        ifRspData_d = mem_spo_i;
                    end else begin
                        lsRspData_d = mem_spo_i;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_q == OWNER_IF) begin
                    if (bus.if_flush || bus.if_rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end else if (bus.ls_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wins over any access in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ifRspData_q <= '0;
            lsRspData_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            ifRspData_q <= ifRspData_d;
            lsRspData_q <= lsRspData_d;
        end
    end

    assign bus.if_req_ready = grantIf;
    assign bus.ls_req_ready = grantLs;
    assign bus.if_rsp_valid = (state_q == S_RESP) && (owner_q == OWNER_IF);
    assign bus.ls_rsp_valid = (state_q == S_RESP) && (owner_q == OWNER_LS);
    assign bus.if_rsp_data  = ifRspData_q;
    assign bus.ls_rsp_data  = lsRspData_q;

    assign mem_we_o = (state_q == S_ACCESS) && we_q;
    assign mem_a_o  = addr_q;
    assign mem_di_o = wdata_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule
